div_unit: RTL and testbench

Multi-cycle RV32M divider for DIV, DIVU, REM and REMU, attached beside the single-cycle ALU in the execute stage. The execute stage issues an operand pair over a valid/ready handshake and holds the pipeline until the divider's one-cycle response strobe. A radix-2 restoring divider produces one quotient bit per cycle, followed by a sign-fix cycle. Divide-by-zero and signed-overflow results follow the RISC-V specification exactly.

---
 rtl/div_unit_pkg.sv | 28 ++
 rtl/div_unit_if.sv | 25 ++
 rtl/div_unit_step.sv | 35 +++
 rtl/div_unit.sv | 151 +++++++++++++++
 tb/tb_div_unit.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants, state encoding and sign helpers for the div_unit slice.
// Op codes follow funct3[1:0] of the RV32M divide instructions.
package div_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_FIX  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

  // Two's-complement negation when neg is set, pass-through otherwise.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage (master) and div_unit (slave).
interface div_unit_if;
  import div_unit_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            rsp_valid;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output req_valid, op, a, b, kill,
    input  req_ready, rsp_valid, result, busy
  );

  modport slave (
    input  req_valid, op, a, b, kill,
    output req_ready, rsp_valid, result, busy
  );

endinterface

// File: rtl/div_unit_step.sv
// One combinational restoring-division iteration: shift {rem,dvd} left,
// subtract the divisor on trial, and shift the resulting quotient bit into dvd.
module div_step (
  input  logic [32:0] rem,
  input  logic [31:0] dvd,
  input  logic [31:0] dvs,
  output logic [32:0] rem_next,
  output logic [31:0] dvd_next
);

  logic [32:0] rem_sh_s;
  logic [32:0] trial_s;
  logic [31:0] dvd_sh_s;
  logic        unused_s;

  // The partial remainder stays below the divisor, so its top bit never feeds the shift.
  assign unused_s = rem[32];
  assign rem_sh_s = {rem[31:0], dvd[31]};
  assign dvd_sh_s = {dvd[30:0], 1'b0};
  assign trial_s  = rem_sh_s - {1'b0, dvs};

  // Keep the trial difference only when it did not go negative.
  always_comb begin
    rem_next = rem_sh_s;
    dvd_next = dvd_sh_s;
    if (trial_s[32] == 1'b0) begin
      rem_next = trial_s;
      dvd_next = {dvd_sh_s[31:1], 1'b1};
    end else begin
      rem_next = rem_sh_s;
      dvd_next = dvd_sh_s;
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU): 32 restoring steps plus a sign-fix cycle.
// Optional macro DIV_FAST_SPECIAL_EN answers divide-by-zero and signed overflow in one cycle.
module div_unit
  import div_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  div_unit_if.slave bus
);

  div_state_e  state_r;
  logic [4:0]  cnt_r;
  logic [1:0]  op_r;
  logic [32:0] rem_r;
  logic [31:0] dvd_r;
  logic [31:0] dvs_r;
  logic [31:0] result_r;
  logic        sign_q_r;
  logic        sign_r_r;
  logic        b_zero_r;
  logic        rsp_valid_r;
  logic        ready_r;
  logic        busy_r;

  logic [32:0] rem_next_s;
  logic [31:0] dvd_next_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;
  logic [31:0] special_res_s;
  logic        signed_op_s;
  logic        special_s;
  logic        unused_s;

  assign signed_op_s = is_signed_op(bus.op);
  // Divide-by-zero keeps the all-ones quotient; the remainder sign fix restores a.
  assign q_fix_s     = mag(dvd_r, sign_q_r & ~b_zero_r);
  assign r_fix_s     = mag(rem_r[31:0], sign_r_r);
  assign unused_s    = op_r[0];

  assign bus.req_ready = ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.result    = result_r;
  assign bus.busy      = busy_r;

  div_step u_step (
    .rem      (rem_r),
    .dvd      (dvd_r),
    .dvs      (dvs_r),
    .rem_next (rem_next_s),
    .dvd_next (dvd_next_s)
  );

`ifdef DIV_FAST_SPECIAL_EN
  // Detect the architecturally fixed results directly from the request operands.
  always_comb begin
    special_s     = 1'b0;
    special_res_s = 32'h0000_0000;
    if (bus.b == 32'h0000_0000) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? bus.a : 32'hFFFF_FFFF;
    end else if (signed_op_s && (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF)) begin
      special_s     = 1'b1;
      special_res_s = bus.op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      special_s     = 1'b0;
      special_res_s = 32'h0000_0000;
    end
  end
`else
  assign special_s     = 1'b0;
  assign special_res_s = 32'h0000_0000;
`endif

  // Control FSM with registered handshake outputs and the iterative datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= DIV_IDLE;
      cnt_r       <= 5'd0;
      op_r        <= 2'b00;
      rem_r       <= 33'd0;
      dvd_r       <= 32'd0;
      dvs_r       <= 32'd0;
      result_r    <= 32'd0;
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      b_zero_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else if (bus.kill) begin
      state_r     <= DIV_IDLE;
      rsp_valid_r <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          rsp_valid_r <= 1'b0;
          if (bus.req_valid && ready_r) begin
            op_r     <= bus.op;
            dvd_r    <= signed_op_s ? mag(bus.a, bus.a[31]) : bus.a;
            dvs_r    <= signed_op_s ? mag(bus.b, bus.b[31]) : bus.b;
            sign_q_r <= signed_op_s & (bus.a[31] ^ bus.b[31]);
            sign_r_r <= signed_op_s & bus.a[31];
            b_zero_r <= (bus.b == 32'h0000_0000);
            rem_r    <= 33'd0;
            cnt_r    <= 5'd31;
            ready_r  <= 1'b0;
            busy_r   <= 1'b1;
            if (special_s) begin
              state_r     <= DIV_DONE;
              result_r    <= special_res_s;
              rsp_valid_r <= 1'b1;
            end else begin
              state_r <= DIV_CALC;
            end
          end else begin
            state_r <= DIV_IDLE;
          end
        end
        DIV_CALC: begin
          rem_r <= rem_next_s;
          dvd_r <= dvd_next_s;
          if (cnt_r == 5'd0) begin
            state_r <= DIV_FIX;
          end else begin
            cnt_r <= cnt_r - 5'd1;
          end
        end
        DIV_FIX: begin
          result_r    <= op_r[1] ? r_fix_s : q_fix_s;
          rsp_valid_r <= 1'b1;
          state_r     <= DIV_DONE;
        end
        DIV_DONE: begin
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
          state_r     <= DIV_IDLE;
        end
        default: begin
          state_r     <= DIV_IDLE;
          rsp_valid_r <= 1'b0;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, results, kill and async reset.
module tb_div_unit;
  import div_unit_pkg::*;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif
  localparam int NORM_LAT = 34;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  div_unit_if bus ();

  div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op in cycle 0, find the response cycle, then check result and handshake.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int c;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.a = 32'hDEAD_BEEF;
    bus.b = 32'h0000_0003;
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    check({tag, "_notready"}, {31'd0, bus.req_ready}, 32'd0);
    c = 1;
    while (bus.rsp_valid !== 1'b1 && c < 60) begin
      @(posedge clk);
      #1;
      c++;
    end
    check({tag, "_lat"}, 32'(c), 32'(exp_lat));
    check({tag, "_res"}, bus.result, exp_res);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, bus.rsp_valid}, 32'd0);
    check({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, "_hold"}, bus.result, exp_res);
  endtask

  // Watch a window of cycles and require that no response strobe shows up.
  task automatic no_rsp(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid === 1'b1) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.op = DIV_OP_DIV;
    bus.a = 32'd0;
    bus.b = 32'd0;
    bus.kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, NORM_LAT);
    run_op("remu_100_7", DIV_OP_REMU, 32'd100, 32'd7, 32'd2, NORM_LAT);
    run_op("div_m7_2", DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, NORM_LAT);
    run_op("rem_m7_2", DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, NORM_LAT);
    run_op("div_7_m2", DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, NORM_LAT);
    run_op("rem_7_m2", DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, NORM_LAT);
    run_op("divu_max_1", DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, NORM_LAT);
    run_op("div_min_1", DIV_OP_DIV, 32'h8000_0000, 32'd1, 32'h8000_0000, NORM_LAT);
    run_op("div_5_0", DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("rem_m5_0", DIV_OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, SPEC_LAT);
    run_op("div_m5_0", DIV_OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("divu_5_0", DIV_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, SPEC_LAT);
    run_op("div_ovf", DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPEC_LAT);
    run_op("rem_ovf", DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPEC_LAT);
    run_op("remu_nonovf", DIV_OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, NORM_LAT);

    // Kill together with a request in IDLE: the request must be dropped.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.kill = 1'b1;
    bus.op = DIV_OP_DIVU;
    bus.a = 32'd50;
    bus.b = 32'd5;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.kill = 1'b0;
    check("killprio_ready", {31'd0, bus.req_ready}, 32'd1);
    check("killprio_busy", {31'd0, bus.busy}, 32'd0);
    no_rsp("killprio_norsp", 40);

    // Kill in cycle 10 of a DIVU.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op = DIV_OP_DIVU;
    bus.a = 32'd1000;
    bus.b = 32'd10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    bus.kill = 1'b1;
    @(posedge clk);
    #1;
    bus.kill = 1'b0;
    check("kill_ready_c11", {31'd0, bus.req_ready}, 32'd1);
    check("kill_busy_c11", {31'd0, bus.busy}, 32'd0);
    check("kill_result_kept", bus.result, 32'h8000_0000);
    no_rsp("kill_norsp", 40);
    run_op("divu_9_3", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, NORM_LAT);

    // Async reset in cycle 20 of an operation.
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.op = DIV_OP_DIVU;
    bus.a = 32'd77;
    bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    repeat (19) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_ready", {31'd0, bus.req_ready}, 32'd1);
    check("arst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    no_rsp("arst_norsp", 40);
    check("arst_result_after", bus.result, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
